// File: rtl/fft_pkg.sv
// Shared types and address helpers for the 8-point radix-2 DIT FFT scheduler.
// Provides the scheduler state encoding, 3-bit bit reversal, and the
// per-stage top/bottom/twiddle address functions for butterfly j of stage s.
package fft_pkg;

    localparam int N     = 8;
    localparam int LOG2N = 3;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_READOUT
    } sched_state_t;

    function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] x);
        return {x[0], x[1], x[2]};
    endfunction

    // top = ((j >> s) << (s + 1)) + (j & (span - 1)), span = 1 << s
    function automatic logic [LOG2N-1:0] top_addr(input logic [1:0] s, input logic [1:0] j);
        case (s)
            2'd0:    return {j, 1'b0};
            2'd1:    return {j[1], 1'b0, j[0]};
            default: return {1'b0, j};
        endcase
    endfunction

    // top never has the span bit set, so OR is the same as adding span
    function automatic logic [LOG2N-1:0] bot_addr(input logic [1:0] s, input logic [1:0] j);
        return top_addr(s, j) | (3'b001 << s);
    endfunction

    // tw = (j & (span - 1)) << (2 - s)
    function automatic logic [LOG2N-1:0] tw_idx(input logic [1:0] s, input logic [1:0] j);
        case (s)
            2'd0:    return 3'd0;
            2'd1:    return {1'b0, j[0], 1'b0};
            default: return {1'b0, j};
        endcase
    endfunction

endpackage

// File: rtl/fft_scheduler_if.sv
// Butterfly-unit link: operand handshake (valid/ready) plus the one-cycle
// result return.
//   master (scheduler): drives bf_valid, operands, bf_tw_idx; receives
//                       bf_ready and the res_* pulse.
//   slave  (butterfly): the mirror image.
interface fft_scheduler_if #(
    parameter int DW = 8
);
    logic                 bf_valid;
    logic                 bf_ready;
    logic signed [DW-1:0] bf_a_r;
    logic signed [DW-1:0] bf_a_i;
    logic signed [DW-1:0] bf_b_r;
    logic signed [DW-1:0] bf_b_i;
    logic [2:0]           bf_tw_idx;
    logic                 res_valid;
    logic signed [DW-1:0] res_yr;
    logic signed [DW-1:0] res_yi;
    logic signed [DW-1:0] res_zr;
    logic signed [DW-1:0] res_zi;

    modport master (
        output bf_valid, bf_a_r, bf_a_i, bf_b_r, bf_b_i, bf_tw_idx,
        input  bf_ready, res_valid, res_yr, res_yi, res_zr, res_zi
    );

    modport slave (
        input  bf_valid, bf_a_r, bf_a_i, bf_b_r, bf_b_i, bf_tw_idx,
        output bf_ready, res_valid, res_yr, res_yi, res_zr, res_zi
    );
endinterface

// File: rtl/fft_sample_ram.sv
// 8-entry complex sample store, entries packed as {re, im}.
//   clk, reset_n  : clock, async active-low clear of all entries
//   i_clr         : synchronous clear of all entries (wins over writes)
//   i_we_a/b, i_wa_addr/i_wb_addr, i_wa_data/i_wb_data : two write ports
//   i_ra_addr/i_rb_addr -> o_ra_data/o_rb_data          : two comb read ports
module fft_sample_ram
    import fft_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_we_a,
    input  logic [LOG2N-1:0] i_wa_addr,
    input  logic [W-1:0]     i_wa_data,
    input  logic             i_we_b,
    input  logic [LOG2N-1:0] i_wb_addr,
    input  logic [W-1:0]     i_wb_data,
    input  logic [LOG2N-1:0] i_ra_addr,
    output logic [W-1:0]     o_ra_data,
    input  logic [LOG2N-1:0] i_rb_addr,
    output logic [W-1:0]     o_rb_data
);

    logic [W-1:0] r_mem [N];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) r_mem[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < N; i++) r_mem[i] <= '0;
        end else begin
            if (i_we_a) r_mem[i_wa_addr] <= i_wa_data;
            if (i_we_b) r_mem[i_wb_addr] <= i_wb_data;
        end
    end

    assign o_ra_data = r_mem[i_ra_addr];
    assign o_rb_data = r_mem[i_rb_addr];

endmodule

// File: rtl/fft_scheduler.sv
// 8-point radix-2 DIT FFT sequencer: loads eight real samples in bit-reversed
// order, issues 12 in-place butterflies to an external unit, then shows the
// results one per ready_in rise.
//   clk, reset_n       : clock, async active-low reset
//   ready_in, data_in  : operator strobe and sample value
//   bf                 : butterfly link (master side)
//   done, out_idx, out_re, out_im : readout of X[out_idx]
//
// state      | meaning
// ST_LOAD    | capture a sample on each ready_in rise
// ST_ISSUE   | bf_valid high, operands held until bf_ready
// ST_WAIT    | one butterfly outstanding, waiting for res_valid
// ST_READOUT | done high, X[out_idx] shown, ready_in rise advances
module fft_scheduler
    import fft_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ready_in,
    input  logic signed [DW-1:0] data_in,
    fft_scheduler_if.master      bf,
    output logic                 done,
    output logic [LOG2N-1:0]     out_idx,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im
);

    sched_state_t     r_state, w_state_nxt;
    logic [LOG2N-1:0] r_load_cnt, r_out_idx;
    logic [1:0]       r_stage, r_bf_cnt;
    logic             r_rdy_prev;

    logic             w_rise, w_last_bf, w_issue, w_readout;
    logic [LOG2N-1:0] w_top, w_bot, w_tw, w_ra_addr;
    logic             w_clr, w_we_a, w_we_b;
    logic [LOG2N-1:0] w_wa_addr, w_wb_addr;
    logic [2*DW-1:0]  w_wa_data, w_wb_data, w_ra_data, w_rb_data;

    assign w_rise    = ready_in & ~r_rdy_prev;
    assign w_last_bf = (r_stage == 2'd2) && (r_bf_cnt == 2'd3);
    assign w_issue   = (r_state == ST_ISSUE);
    assign w_readout = (r_state == ST_READOUT);
    assign w_top     = top_addr(r_stage, r_bf_cnt);
    assign w_bot     = bot_addr(r_stage, r_bf_cnt);
    assign w_tw      = tw_idx(r_stage, r_bf_cnt);
    // port a serves the top operand while computing and the display afterwards
    assign w_ra_addr = w_readout ? r_out_idx : w_top;

    fft_sample_ram #(.W(2*DW)) u_ram (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clr     (w_clr),
        .i_we_a    (w_we_a),
        .i_wa_addr (w_wa_addr),
        .i_wa_data (w_wa_data),
        .i_we_b    (w_we_b),
        .i_wb_addr (w_wb_addr),
        .i_wb_data (w_wb_data),
        .i_ra_addr (w_ra_addr),
        .o_ra_data (w_ra_data),
        .i_rb_addr (w_bot),
        .o_rb_data (w_rb_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_LOAD;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_we_a      = 1'b0;
        w_we_b      = 1'b0;
        w_wa_addr   = '0;
        w_wb_addr   = '0;
        w_wa_data   = '0;
        w_wb_data   = '0;
        case (r_state)
            ST_LOAD: begin
                if (w_rise) begin
                    w_we_a    = 1'b1;
                    w_wa_addr = bitrev3(r_load_cnt);
                    w_wa_data = {data_in, {DW{1'b0}}};
                    if (r_load_cnt == 3'd7) w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bf.bf_ready) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bf.res_valid) begin
                    w_we_a      = 1'b1;
                    w_wa_addr   = w_top;
                    w_wa_data   = {bf.res_yr, bf.res_yi};
                    w_we_b      = 1'b1;
                    w_wb_addr   = w_bot;
                    w_wb_data   = {bf.res_zr, bf.res_zi};
                    w_state_nxt = w_last_bf ? ST_READOUT : ST_ISSUE;
                end
            end
            ST_READOUT: begin
                if (w_rise && (r_out_idx == 3'd7)) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_load_cnt <= '0;
            r_stage    <= '0;
            r_bf_cnt   <= '0;
            r_out_idx  <= '0;
            r_rdy_prev <= 1'b0;
        end else begin
            r_rdy_prev <= ready_in;
            if ((r_state == ST_LOAD) && w_rise) r_load_cnt <= r_load_cnt + 3'd1;
            if (w_clr) r_load_cnt <= '0;
            // counters advance with the write so the next ISSUE addresses fresh data
            if ((r_state == ST_WAIT) && bf.res_valid) begin
                r_bf_cnt <= r_bf_cnt + 2'd1;
                if (r_bf_cnt == 2'd3) r_stage <= (r_stage == 2'd2) ? 2'd0 : r_stage + 2'd1;
            end
            if (w_readout && w_rise) r_out_idx <= r_out_idx + 3'd1;
        end
    end

    assign bf.bf_valid  = w_issue;
    assign bf.bf_a_r    = w_issue ? w_ra_data[2*DW-1:DW] : '0;
    assign bf.bf_a_i    = w_issue ? w_ra_data[DW-1:0]    : '0;
    assign bf.bf_b_r    = w_issue ? w_rb_data[2*DW-1:DW] : '0;
    assign bf.bf_b_i    = w_issue ? w_rb_data[DW-1:0]    : '0;
    assign bf.bf_tw_idx = w_issue ? w_tw : '0;

    assign done    = w_readout;
    assign out_idx = r_out_idx;
    assign out_re  = w_readout ? w_ra_data[2*DW-1:DW] : '0;
    assign out_im  = w_readout ? w_ra_data[DW-1:0]    : '0;

endmodule

// File: tb/tb_fft_scheduler.sv
// Bench for fft_scheduler: emulates the butterfly unit, predicts results with
// an independent loop-form FFT, and checks schedule, backpressure, reset and
// readout behaviour.
module tb_fft_scheduler;

    localparam int DW = 8;
    typedef logic signed [7:0] s8_t;
    typedef int frame_t [8];
    typedef struct packed { logic [2:0] top; logic [2:0] bot; logic [2:0] tw; } sched_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ready_in = 1'b0;
    s8_t        data_in = '0;
    logic       done;
    logic [2:0] out_idx;
    s8_t        out_re, out_im;

    fft_scheduler_if #(.DW(DW)) bfi();

    fft_scheduler #(.DW(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ready_in(ready_in),
        .data_in (data_in),
        .bf      (bfi),
        .done    (done),
        .out_idx (out_idx),
        .out_re  (out_re),
        .out_im  (out_im)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     exp_re_q[$];
    int     exp_im_q[$];
    sched_t sched_q[$];

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic int wrap8(input int v);
        s8_t t;
        t = s8_t'(v);
        return int'(t);
    endfunction

    function automatic int cmul(input int v);
        return (v * 181 + 128) >>> 8;   // v * cos(pi/4), rounded
    endfunction

    // ideal butterfly: y = a + W^k b, z = a - W^k b, W = e^(-j*2*pi/8)
    function automatic void bfly(input int ar, input int ai, input int br, input int bi, input int k,
                                 output int yr, output int yi, output int zr, output int zi);
        int tr, ti;
        case (k)
            0:       begin tr = br;              ti = bi;               end
            1:       begin tr = cmul(br + bi);   ti = cmul(bi - br);    end
            2:       begin tr = bi;              ti = -br;              end
            default: begin tr = cmul(bi - br);   ti = -cmul(br + bi);   end
        endcase
        yr = wrap8(ar + tr); yi = wrap8(ai + ti);
        zr = wrap8(ar - tr); zi = wrap8(ai - ti);
    endfunction

    function automatic void ref_fft(input frame_t x);
        int re[8], im[8];
        logic [2:0] b;
        for (int i = 0; i < 8; i++) begin
            b = 3'(i);
            re[int'({b[0], b[1], b[2]})] = x[i];
            im[int'({b[0], b[1], b[2]})] = 0;
        end
        for (int half = 1; half < 8; half = half * 2)
            for (int base = 0; base < 8; base = base + 2 * half)
                for (int k = 0; k < half; k++) begin
                    int t, u, yr, yi, zr, zi;
                    t = base + k; u = t + half;
                    bfly(re[t], im[t], re[u], im[u], k * 4 / half, yr, yi, zr, zi);
                    re[t] = yr; im[t] = yi; re[u] = zr; im[u] = zi;
                end
        for (int i = 0; i < 8; i++) begin
            exp_re_q.push_back(re[i]);
            exp_im_q.push_back(im[i]);
        end
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; ready_in = 1'b0; data_in = '0;
        bfi.bf_ready = 1'b0; bfi.res_valid = 1'b0;
        exp_re_q.delete(); exp_im_q.delete(); sched_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_frame(input frame_t x);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); data_in = s8_t'(x[i]); ready_in = 1'b1;
            @(negedge clk); ready_in = 1'b0;
        end
    endtask

    // acts as the butterfly unit for one operation
    task automatic serve_bf(input int hold, input int lat, output s8_t ar, output s8_t ai,
                            output s8_t br, output s8_t bi, output logic [2:0] tw, output bit to);
        int n, yr, yi, zr, zi;
        to = 1'b0; n = 0;
        ar = '0; ai = '0; br = '0; bi = '0; tw = '0;
        @(negedge clk);
        while (bfi.bf_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (bfi.bf_valid !== 1'b1) begin to = 1'b1; return; end
        repeat (hold) @(negedge clk);
        ar = bfi.bf_a_r; ai = bfi.bf_a_i; br = bfi.bf_b_r; bi = bfi.bf_b_i; tw = bfi.bf_tw_idx;
        bfi.bf_ready = 1'b1;
        @(negedge clk); bfi.bf_ready = 1'b0;
        repeat (lat) @(negedge clk);
        bfly(int'(ar), int'(ai), int'(br), int'(bi), int'(tw), yr, yi, zr, zi);
        bfi.res_yr = s8_t'(yr); bfi.res_yi = s8_t'(yi);
        bfi.res_zr = s8_t'(zr); bfi.res_zi = s8_t'(zi);
        bfi.res_valid = 1'b1;
        @(negedge clk); bfi.res_valid = 1'b0;
    endtask

    task automatic compute_frame(input int count, output int to);
        s8_t ar, ai, br, bi; logic [2:0] tw; bit t;
        to = 0;
        for (int n = 0; n < count; n++) begin
            serve_bf(n % 3, n % 2, ar, ai, br, bi, tw, t);
            if (t) begin to++; return; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (bfi.bf_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bf_valid got=%b exp=0", bfi.bf_valid); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (out_idx !== 3'd0) begin n_fail++; $display("FAIL reset_out_idx got=%0d exp=0", out_idx); end
        n_checks++; if (out_re !== 8'sd0 || out_im !== 8'sd0) begin n_fail++; $display("FAIL reset_out got=%0d,%0d exp=0,0", out_re, out_im); end
        n_checks++; if (bfi.bf_a_r !== 8'sd0 || bfi.bf_b_r !== 8'sd0 || bfi.bf_tw_idx !== 3'd0) begin
            n_fail++; $display("FAIL reset_operands got a=%0d b=%0d tw=%0d exp 0", bfi.bf_a_r, bfi.bf_b_r, bfi.bf_tw_idx); end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bfi.bf_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_release got valid=%b done=%b exp 0 0", bfi.bf_valid, done); end
    endtask

    task automatic test_impulse();
        frame_t x = '{64, 0, 0, 0, 0, 0, 0, 0};
        int to;
        do_reset();
        for (int k = 0; k < 8; k++) begin exp_re_q.push_back(64); exp_im_q.push_back(0); end
        load_frame(x);
        compute_frame(12, to);
        n_checks++; if (to != 0) begin n_fail++; $display("FAIL impulse_timeout got=%0d exp=0", to); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL impulse_done got=%b exp=1", done); end
        for (int k = 0; k < 8; k++) begin
            int er, ei;
            er = exp_re_q.pop_front(); ei = exp_im_q.pop_front();
            @(negedge clk);
            n_checks++;
            if (out_idx !== 3'(k) || out_re !== s8_t'(er) || out_im !== s8_t'(ei) || done !== 1'b1) begin
                n_fail++; $display("FAIL impulse_out k=%0d got idx=%0d re=%0d im=%0d done=%b exp re=%0d im=%0d", k, out_idx, out_re, out_im, done, er, ei);
            end
            ready_in = 1'b1; @(negedge clk); ready_in = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || out_idx !== 3'd0) begin n_fail++; $display("FAIL impulse_back_to_load got done=%b idx=%0d exp 0 0", done, out_idx); end
    endtask

    task automatic test_dc();
        frame_t x = '{8, 8, 8, 8, 8, 8, 8, 8};
        int to;
        do_reset();
        exp_re_q.push_back(64); exp_im_q.push_back(0);
        for (int k = 1; k < 8; k++) begin exp_re_q.push_back(0); exp_im_q.push_back(0); end
        load_frame(x);
        compute_frame(12, to);
        n_checks++; if (to != 0 || done !== 1'b1) begin n_fail++; $display("FAIL dc_compute got timeouts=%0d done=%b exp 0 1", to, done); end
        for (int k = 0; k < 8; k++) begin
            int er, ei;
            er = exp_re_q.pop_front(); ei = exp_im_q.pop_front();
            @(negedge clk);
            n_checks++;
            if (out_idx !== 3'(k) || out_re !== s8_t'(er) || out_im !== s8_t'(ei)) begin
                n_fail++; $display("FAIL dc_out k=%0d got idx=%0d re=%0d im=%0d exp re=%0d im=%0d", k, out_idx, out_re, out_im, er, ei);
            end
            ready_in = 1'b1; @(negedge clk); ready_in = 1'b0;
        end
    endtask

    task automatic test_schedule();
        frame_t x = '{3, -5, 7, 2, -1, 6, -4, 1};
        int tops[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        int bots[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        int tws[12]  = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
        int sr[8], si[8];
        logic [2:0] b;
        sched_t e;
        s8_t ar, ai, br, bi; logic [2:0] tw; bit t;
        int yr, yi, zr, zi;
        do_reset();
        for (int n = 0; n < 12; n++) begin
            e.top = 3'(tops[n]); e.bot = 3'(bots[n]); e.tw = 3'(tws[n]);
            sched_q.push_back(e);
        end
        for (int i = 0; i < 8; i++) begin
            b = 3'(i);
            sr[int'({b[0], b[1], b[2]})] = x[i];
            si[int'({b[0], b[1], b[2]})] = 0;
        end
        ref_fft(x);
        load_frame(x);
        for (int n = 0; n < 12; n++) begin
            serve_bf(1, n % 3, ar, ai, br, bi, tw, t);
            e = sched_q.pop_front();
            n_checks++; if (t) begin n_fail++; $display("FAIL sched_timeout bf=%0d got timeout exp valid", n); break; end
            if (n == 0) begin
                n_checks++; if (ar !== s8_t'(x[0]) || br !== s8_t'(x[4])) begin
                    n_fail++; $display("FAIL sched_first got a=%0d b=%0d exp a=%0d b=%0d", ar, br, x[0], x[4]); end
            end
            n_checks++; if (tw !== e.tw) begin n_fail++; $display("FAIL sched_tw bf=%0d got=%0d exp=%0d", n, tw, e.tw); end
            n_checks++;
            if (ar !== s8_t'(sr[e.top]) || ai !== s8_t'(si[e.top]) || br !== s8_t'(sr[e.bot]) || bi !== s8_t'(si[e.bot])) begin
                n_fail++; $display("FAIL sched_operands bf=%0d got a=%0d,%0d b=%0d,%0d exp a=%0d,%0d b=%0d,%0d (top=%0d bot=%0d)",
                                   n, ar, ai, br, bi, sr[e.top], si[e.top], sr[e.bot], si[e.bot], e.top, e.bot);
            end
            bfly(sr[e.top], si[e.top], sr[e.bot], si[e.bot], int'(e.tw), yr, yi, zr, zi);
            sr[e.top] = yr; si[e.top] = yi; sr[e.bot] = zr; si[e.bot] = zi;
        end
        for (int k = 0; k < 8; k++) begin
            int er, ei;
            er = exp_re_q.pop_front(); ei = exp_im_q.pop_front();
            @(negedge clk);
            n_checks++;
            if (out_idx !== 3'(k) || out_re !== s8_t'(er) || out_im !== s8_t'(ei)) begin
                n_fail++; $display("FAIL sched_out k=%0d got idx=%0d re=%0d im=%0d exp re=%0d im=%0d", k, out_idx, out_re, out_im, er, ei);
            end
            ready_in = 1'b1; @(negedge clk); ready_in = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        frame_t x = '{10, -3, 5, 8, -7, 2, 0, -12};
        s8_t a_r, a_i, b_r, b_i; logic [2:0] tw0;
        int n, to;
        do_reset();
        ref_fft(x);
        load_frame(x);
        n = 0;
        @(negedge clk);
        while (bfi.bf_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_checks++; if (bfi.bf_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_rise got=%b exp=1", bfi.bf_valid); end
        a_r = bfi.bf_a_r; a_i = bfi.bf_a_i; b_r = bfi.bf_b_r; b_i = bfi.bf_b_i; tw0 = bfi.bf_tw_idx;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (bfi.bf_valid !== 1'b1 || bfi.bf_a_r !== a_r || bfi.bf_a_i !== a_i || bfi.bf_b_r !== b_r || bfi.bf_b_i !== b_i || bfi.bf_tw_idx !== tw0) begin
                n_fail++; $display("FAIL bp_hold c=%0d got valid=%b a=%0d b=%0d exp valid=1 a=%0d b=%0d", c, bfi.bf_valid, bfi.bf_a_r, bfi.bf_b_r, a_r, b_r);
            end
            // stray result while still in ISSUE must not touch the store
            bfi.res_valid = (c == 1);
            bfi.res_yr = 8'sd99; bfi.res_yi = -8'sd77; bfi.res_zr = 8'sd55; bfi.res_zi = -8'sd33;
        end
        bfi.res_valid = 1'b0;
        compute_frame(12, to);
        n_checks++; if (to != 0 || done !== 1'b1) begin n_fail++; $display("FAIL bp_compute got timeouts=%0d done=%b exp 0 1", to, done); end
        for (int k = 0; k < 8; k++) begin
            int er, ei;
            er = exp_re_q.pop_front(); ei = exp_im_q.pop_front();
            @(negedge clk);
            n_checks++;
            if (out_idx !== 3'(k) || out_re !== s8_t'(er) || out_im !== s8_t'(ei)) begin
                n_fail++; $display("FAIL bp_out k=%0d got idx=%0d re=%0d im=%0d exp re=%0d im=%0d", k, out_idx, out_re, out_im, er, ei);
            end
            ready_in = 1'b1; @(negedge clk); ready_in = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        frame_t x1 = '{-8, 4, 12, -6, 3, 9, -2, 5};
        frame_t x2 = '{7, -3, 0, 11, -9, 4, 6, -1};
        int to;
        do_reset();
        load_frame(x1);
        compute_frame(5, to);
        @(negedge clk);
        n_checks++; if (to != 0 || bfi.bf_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got timeouts=%0d valid=%b exp 0 1", to, bfi.bf_valid); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (bfi.bf_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async got valid=%b done=%b exp 0 0", bfi.bf_valid, done); end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); bfi.res_yr = 8'sd100; bfi.res_zr = -8'sd100; bfi.res_valid = 1'b1;
        @(negedge clk); bfi.res_valid = 1'b0;
        n_checks++; if (bfi.bf_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_late_res got valid=%b done=%b exp 0 0", bfi.bf_valid, done); end
        ref_fft(x2);
        load_frame(x2);
        compute_frame(12, to);
        n_checks++; if (to != 0 || done !== 1'b1) begin n_fail++; $display("FAIL rst_mid_compute got timeouts=%0d done=%b exp 0 1", to, done); end
        for (int k = 0; k < 8; k++) begin
            int er, ei;
            er = exp_re_q.pop_front(); ei = exp_im_q.pop_front();
            @(negedge clk);
            n_checks++;
            if (out_idx !== 3'(k) || out_re !== s8_t'(er) || out_im !== s8_t'(ei)) begin
                n_fail++; $display("FAIL rst_mid_out k=%0d got idx=%0d re=%0d im=%0d exp re=%0d im=%0d", k, out_idx, out_re, out_im, er, ei);
            end
            ready_in = 1'b1; @(negedge clk); ready_in = 1'b0;
        end
    endtask

    task automatic test_readout_hold();
        frame_t x = '{8, 8, 8, 8, 8, 8, 8, 8};
        int to;
        do_reset();
        load_frame(x);
        compute_frame(12, to);
        @(negedge clk);
        n_checks++; if (to != 0 || done !== 1'b1 || out_idx !== 3'd0 || out_re !== 8'sd64) begin
            n_fail++; $display("FAIL hold_start got timeouts=%0d done=%b idx=%0d re=%0d exp 0 1 0 64", to, done, out_idx, out_re); end
        ready_in = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++; if (out_idx !== 3'd1) begin n_fail++; $display("FAIL hold_single_advance got=%0d exp=1", out_idx); end
        ready_in = 1'b0;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            n_checks++; if (out_idx !== 3'(k) || out_re !== 8'sd0 || done !== 1'b1) begin
                n_fail++; $display("FAIL hold_step k=%0d got idx=%0d re=%0d done=%b exp idx=%0d re=0 done=1", k, out_idx, out_re, done, k); end
            ready_in = 1'b1; @(negedge clk); ready_in = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || out_idx !== 3'd0 || bfi.bf_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_return got done=%b idx=%0d valid=%b exp 0 0 0", done, out_idx, bfi.bf_valid); end
    endtask

    initial begin
        bfi.bf_ready = 1'b0; bfi.res_valid = 1'b0;
        bfi.res_yr = '0; bfi.res_yi = '0; bfi.res_zr = '0; bfi.res_zi = '0;
        test_reset();
        test_impulse();
        test_dc();
        test_schedule();
        test_backpressure();
        test_reset_mid();
        test_readout_hold();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_scheduler.md
# fft_scheduler

Sequencer and working store for the 8-point radix-2 DIT FFT. It loads eight real samples from the switch bank in bit-reversed order and issues 12 butterfly operations (3 stages × 4) to the downstream butterfly unit over a valid/ready handshake. It writes each returned y/z pair back in place, then presents the eight complex results one per `ready_in` edge for LED display.

## Interface
Parameters:
- `DW`, 8: sample width, signed two's complement, real and imaginary parts each.

Ports:
- `clk`  in  1: single clock; all logic in this one clock domain.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ready_in`  in  1: operator strobe, already synchronous to `clk`; a rising edge is `ready_in & ~rdy_prev`.
- `data_in`  in  DW: real sample value during LOAD.
- `bf_valid`  out  1: butterfly operands valid.
- `bf_ready`  in  1: butterfly accepts operands.
- `bf_a_r`, `bf_a_i`, `bf_b_r`, `bf_b_i`  out  DW each: operands a and b.
- `bf_tw_idx`  out  3: twiddle index k for W8^k = e^(-j2πk/8).
- `res_valid`  in  1: one-cycle pulse carrying the butterfly result.
- `res_yr`, `res_yi`, `res_zr`, `res_zi`  in  DW each: y = a + W·b and z = a − W·b.
- `done`  out  1: high throughout READOUT.
- `out_idx`  out  3: index k of the displayed result.
- `out_re`, `out_im`  out  DW each: X[k].

## Operation
- States: LOAD, ISSUE, WAIT, READOUT. Reset value is LOAD.
- Reset values:
  - all outputs 0;
  - the 8-entry memory is cleared to 0;
  - `load_cnt`, `stage`, `bf_cnt`, `out_idx` and `rdy_prev` are 0.
- `rdy_prev <= ready_in` every cycle, in every state.
- LOAD:
  - on each rising edge of `ready_in`, write `{data_in, 0}` to address `bitrev(load_cnt)`, then increment `load_cnt`;
  - on the 8th capture, go to ISSUE with `stage=0` and `bf_cnt=0`.
- Addressing for stage s, butterfly j:
  - span = 1<<s;
  - top = ((j>>s)<<(s+1)) + (j & (span−1));
  - bot = top + span;
  - tw = (j & (span−1)) << (2−s).
- ISSUE:
  - `bf_valid=1`, with a = mem[top] and b = mem[bot];
  - operands and `bf_tw_idx` are held stable until transfer (`bf_valid & bf_ready`);
  - on transfer go to WAIT, and `bf_valid` drops the next cycle.
- WAIT:
  - on `res_valid`, write y to mem[top] and z to mem[bot] at the same clock edge;
  - advance `bf_cnt`; it wraps 3→0 and increments `stage`;
  - after stage 2, butterfly 3, go to READOUT with `out_idx=0`; otherwise go to ISSUE.
- Only one butterfly is ever outstanding.
- `res_valid` outside WAIT is ignored.
- READOUT:
  - `out_re`/`out_im` = mem[out_idx] and `done=1`;
  - each `ready_in` rise increments `out_idx`;
  - a rise at `out_idx=7` returns to LOAD with `done=0`, `load_cnt=0` and the memory cleared.
- Ignored inputs:
  - `data_in` outside LOAD;
  - `ready_in` edges in ISSUE and WAIT;
  - a held-high `ready_in`, which gives no repeated edges.
- Arithmetic: the scheduler performs none. Results are stored exactly as returned; scaling and overflow belong to the butterfly.
- Reset mid-operation: the block returns immediately to the reset values above. The butterfly in flight is abandoned, and a late `res_valid` after reset is ignored.

## Timing
- `bf_valid` rises on the first clock after the 8th load edge.
- Per butterfly: ≥1 cycle in ISSUE, then WAIT until `res_valid`. The next `bf_valid` is asserted the cycle after `res_valid`.
- The memory write and the next read address update occur at the same edge, so the next ISSUE sees the updated data.
- `done` rises the cycle after the final `res_valid`.
- `out_re`/`out_im`/`out_idx` update the cycle after each `ready_in` rise.

## Structure
- Package `fft_pkg`:
  - `N=8`, `LOG2N=3`;
  - a `sched_state_t` enum;
  - a `bitrev3` function;
  - top/bot/tw address functions.
- Sub-module `fft_sample_ram`: 8 × 2·DW, two combinational read ports, two synchronous write ports, async clear on `reset_n` plus a synchronous clear input.
- All FSM, counter and handshake logic stays in `fft_scheduler`.

## Test plan
- Impulse: load 64,0,0,0,0,0,0,0 with an ideal Q1.7 butterfly model → all eight results 64+0j, `done`=1.
- DC: load eight 8s → X[0]=64+0j, X[1..7]=0+0j.
- Schedule order:
  - (top,bot) issued = (0,1)(2,3)(4,5)(6,7)(0,2)(1,3)(4,6)(5,7)(0,4)(1,5)(2,6)(3,7);
  - `bf_tw_idx` = 0,0,0,0,0,2,0,2,0,1,2,3;
  - first butterfly a=x[0], b=x[4].
- Backpressure: hold `bf_ready` low 5 cycles → `bf_valid` stays 1 and the operands stay unchanged; a stray `res_valid` pulsed during ISSUE → the memory is unchanged.
- Reset after the 5th butterfly → same cycle `bf_valid=0`, `done=0`; a fresh 8-sample load then computes correct results.
- Readout:
  - 8 `ready_in` rises step `out_idx` 0..7 and then return to LOAD;
  - `ready_in` held high for 20 cycles → exactly one advance.
